// File: rtl/regfile_pkg.sv
// Shared constants, helpers and types for the register-file write scheduler.
package regfile_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefSize  = 8;
  localparam int unsigned DefNreq  = 3;

  function automatic int unsigned addr_width(input int unsigned size);
    return $clog2(size);
  endfunction

  // Packed bundle of all requesters at the default configuration.
  typedef struct packed {
    logic [DefNreq-1:0]                       valid;
    logic [DefNreq*addr_width(DefSize)-1:0]   addr;
    logic [DefNreq*DefWidth-1:0]              data;
  } req_bundle_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the last one served.
module rr_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] valid_i,
  input  logic            advance_i,
  output logic [NREQ-1:0] grant_o
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);

  logic [IdxW-1:0] last_q, last_d, idx;
  logic            found;

  always_comb begin
    grant_o = '0;
    last_d  = last_q;
    idx     = last_q;
    found   = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (idx == LastIdx) ? '0 : idx + IdxW'(1);
      if (!found && valid_i[idx]) begin
        grant_o[idx] = 1'b1;
        last_d       = idx;
        found        = 1'b1;
      end
    end
  end

  // Reset to the top index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= LastIdx;
    end else if (advance_i) begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register-file write port among requesters and tracks pending destinations.
module regfile_write_scheduler
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SIZE  = DefSize,
  parameter int unsigned NREQ  = DefNreq,
  localparam int unsigned ADDR_WIDTH = addr_width(SIZE)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NREQ*WIDTH-1:0]      req_data_i,
  output logic                       rf_write_o,
  output logic [ADDR_WIDTH-1:0]      rf_writenum_o,
  output logic [WIDTH-1:0]           rf_data_in_o,
  input  logic                       rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]      rsv_addr_i,
  output logic                       rsv_ready_o,
  output logic [SIZE-1:0]            busy_o,
  input  logic [ADDR_WIDTH-1:0]      readnum1_i,
  input  logic [ADDR_WIDTH-1:0]      readnum2_i,
  output logic                       hazard1_o,
  output logic                       hazard2_o
);

  logic [NREQ-1:0]       grant;
  logic                  transfer;
  logic                  clr_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0]      sel_data;

  logic                  rf_write_q;
  logic [ADDR_WIDTH-1:0] rf_writenum_q;
  logic [WIDTH-1:0]      rf_data_in_q;
  logic [SIZE-1:0]       busy_q, busy_d;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (req_valid_i),
    .advance_i(transfer),
    .grant_o  (grant)
  );

  assign req_ready_o = grant;
  assign transfer    = |grant;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (grant[i]) begin
        sel_addr = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // A write retiring the same register frees the slot for a new reservation.
  assign clr_hit     = transfer & (sel_addr == rsv_addr_i);
  assign rsv_ready_o = rsv_valid_i & (~busy_q[rsv_addr_i] | clr_hit);

  always_comb begin
    busy_d = busy_q;
    if (transfer) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (rsv_ready_o) begin
      busy_d[rsv_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_write_q    <= 1'b0;
      rf_writenum_q <= '0;
      rf_data_in_q  <= '0;
      busy_q        <= '0;
    end else begin
      rf_write_q <= transfer;
      busy_q     <= busy_d;
      if (transfer) begin
        rf_writenum_q <= sel_addr;
        rf_data_in_q  <= sel_data;
      end
    end
  end

  assign rf_write_o    = rf_write_q;
  assign rf_writenum_o = rf_writenum_q;
  assign rf_data_in_o  = rf_data_in_q;
  assign busy_o        = busy_q;

  // The in-flight term covers the cycle after busy clears but before the file updates.
  assign hazard1_o = busy_q[readnum1_i] | (rf_write_q & (rf_writenum_q == readnum1_i));
  assign hazard2_o = busy_q[readnum2_i] | (rf_write_q & (rf_writenum_q == readnum2_i));

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Self-checking bench: arbitration table, directed scoreboard/reset sequences, random vs model.
module tb_regfile_write_scheduler;
  import regfile_pkg::*;

  localparam int unsigned W  = 16;
  localparam int unsigned S  = 8;
  localparam int unsigned N  = 3;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  req_bundle_t   req;
  logic [N-1:0]  req_ready;
  logic          rf_write;
  logic [AW-1:0] rf_writenum;
  logic [W-1:0]  rf_data_in;
  logic          rsv_valid;
  logic [AW-1:0] rsv_addr;
  logic          rsv_ready;
  logic [S-1:0]  busy;
  logic [AW-1:0] readnum1, readnum2;
  logic          hazard1, hazard2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(
    .WIDTH(W),
    .SIZE (S),
    .NREQ (N)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req.valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req.addr),
    .req_data_i   (req.data),
    .rf_write_o   (rf_write),
    .rf_writenum_o(rf_writenum),
    .rf_data_in_o (rf_data_in),
    .rsv_valid_i  (rsv_valid),
    .rsv_addr_i   (rsv_addr),
    .rsv_ready_o  (rsv_ready),
    .busy_o       (busy),
    .readnum1_i   (readnum1),
    .readnum2_i   (readnum2),
    .hazard1_o    (hazard1),
    .hazard2_o    (hazard2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
    req.addr[i*AW +: AW] = a;
    req.data[i*W +: W]   = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    readnum1  = '0;
    readnum2  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_write", 32'(rf_write), 32'd0);
    chk("reset_writenum", 32'(rf_writenum), 32'd0);
    chk("reset_data_in", 32'(rf_data_in), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0]  valid;
    logic [N-1:0]  exp_ready;
    logic [AW-1:0] exp_wnum;
  } arb_vec_t;

  arb_vec_t vecs[13];

  // Behavioural model state for the random phase.
  bit            pend[N];
  logic [AW-1:0] paddr[N];
  logic [W-1:0]  pdata[N];
  int            m_last;
  bit [S-1:0]    m_busy;
  bit            m_w;
  logic [AW-1:0] m_wa;
  logic [W-1:0]  m_wd;

  initial begin
    // Fixed destinations: requester 0 -> r1, 1 -> r2, 2 -> r6.
    vecs[0]  = '{3'b111, 3'b001, 3'd1};
    vecs[1]  = '{3'b110, 3'b010, 3'd2};
    vecs[2]  = '{3'b100, 3'b100, 3'd6};
    vecs[3]  = '{3'b000, 3'b000, 3'd6};
    vecs[4]  = '{3'b011, 3'b001, 3'd1};
    vecs[5]  = '{3'b010, 3'b010, 3'd2};
    vecs[6]  = '{3'b101, 3'b100, 3'd6};
    vecs[7]  = '{3'b001, 3'b001, 3'd1};
    vecs[8]  = '{3'b110, 3'b010, 3'd2};
    vecs[9]  = '{3'b100, 3'b100, 3'd6};
    vecs[10] = '{3'b111, 3'b001, 3'd1};
    vecs[11] = '{3'b110, 3'b010, 3'd2};
    vecs[12] = '{3'b100, 3'b100, 3'd6};

    do_reset();

    // Post-reset single writer.
    req.valid = 3'b001;
    set_req(0, 3'd3, 16'hBEEF);
    #1 chk("single_ready", 32'(req_ready), 32'b001);
    tick();
    req.valid = '0;
    chk("single_write", 32'(rf_write), 32'd1);
    chk("single_wnum", 32'(rf_writenum), 32'd3);
    chk("single_data", 32'(rf_data_in), 32'hBEEF);
    tick();
    chk("single_idle", 32'(rf_write), 32'd0);
    chk("single_hold_wnum", 32'(rf_writenum), 32'd3);

    // Arbitration table; last pointer is at requester 0 now.
    vecs[0].exp_ready = 3'b010;
    vecs[0].exp_wnum  = 3'd2;
    vecs[1].exp_ready = 3'b100;
    vecs[1].exp_wnum  = 3'd6;
    vecs[2].exp_ready = 3'b100;
    vecs[2].exp_wnum  = 3'd6;
    vecs[3].exp_wnum  = 3'd6;
    for (int k = 0; k < 13; k++) begin
      logic [W-1:0] exp_d;
      req.valid = vecs[k].valid;
      set_req(0, 3'd1, 16'h1000 + 16'(k));
      set_req(1, 3'd2, 16'h2000 + 16'(k));
      set_req(2, 3'd6, 16'h3000 + 16'(k));
      exp_d = rf_data_in;
      for (int i = 0; i < int'(N); i++)
        if (vecs[k].exp_ready[i]) exp_d = 16'h1000 * 16'(i + 1) + 16'(k);
      #1 chk($sformatf("arb_ready[%0d]", k), 32'(req_ready), 32'(vecs[k].exp_ready));
      tick();
      chk($sformatf("arb_write[%0d]", k), 32'(rf_write), 32'(|vecs[k].exp_ready));
      chk($sformatf("arb_wnum[%0d]", k), 32'(rf_writenum), 32'(vecs[k].exp_wnum));
      chk($sformatf("arb_data[%0d]", k), 32'(rf_data_in), 32'(exp_d));
    end
    req.valid = '0;

    // Scoreboard: reserve r5, watch readnum1, then requester 1 writes r5.
    do_reset();
    readnum1  = 3'd5;
    readnum2  = 3'd4;
    rsv_valid = 1'b1;
    rsv_addr  = 3'd5;
    #1 chk("rsv5_ready", 32'(rsv_ready), 32'd1);
    chk("rsv5_haz_before", 32'(hazard1), 32'd0);
    tick();
    chk("rsv5_busy", 32'(busy), 32'h20);
    chk("rsv5_haz1", 32'(hazard1), 32'd1);
    chk("rsv5_haz2", 32'(hazard2), 32'd0);
    #1 chk("rsv5_again_refused", 32'(rsv_ready), 32'd0);
    tick();
    rsv_valid = 1'b0;
    chk("rsv5_busy_unchanged", 32'(busy), 32'h20);
    req.valid = 3'b010;
    set_req(1, 3'd5, 16'h5A5A);
    #1 chk("wr5_ready", 32'(req_ready), 32'b010);
    chk("wr5_haz_T", 32'(hazard1), 32'd1);
    tick();
    req.valid = '0;
    chk("wr5_busy_cleared", 32'(busy), 32'h00);
    chk("wr5_haz_T1", 32'(hazard1), 32'd1);
    chk("wr5_wnum", 32'(rf_writenum), 32'd5);
    tick();
    chk("wr5_haz_T2", 32'(hazard1), 32'd0);

    // Simultaneous clear and reserve of r2.
    rsv_valid = 1'b1;
    rsv_addr  = 3'd2;
    tick();
    chk("r2_busy", 32'(busy), 32'h04);
    req.valid = 3'b001;
    set_req(0, 3'd2, 16'h2222);
    #1 chk("r2_rsv_with_clear", 32'(rsv_ready), 32'd1);
    tick();
    chk("r2_set_wins", 32'(busy), 32'h04);

    // Reset mid-operation, with the pointer left at requester 1.
    req.valid = 3'b010;
    set_req(1, 3'd7, 16'h7777);
    rsv_addr = 3'd5;
    tick();
    rsv_valid = 1'b0;
    req.valid = 3'b111;
    chk("mid_rf_write", 32'(rf_write), 32'd1);
    chk("mid_busy", 32'(busy), 32'h24);
    #2 rst_n = 1'b0;
    #1 chk("async_rf_write", 32'(rf_write), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_reset_grant", 32'(req_ready), 32'b001);
    req.valid = '0;

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < int'(N); i++) pend[i] = 1'b0;
    m_last = int'(N) - 1;
    m_busy = '0;
    m_w    = 1'b0;
    m_wa   = '0;
    m_wd   = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      bit exp_rsv, clr, h1, h2;
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1'b1;
          paddr[i] = 3'($urandom_range(0, S - 1));
          pdata[i] = 16'($urandom);
        end
        req.valid[i] = pend[i];
        set_req(i, paddr[i], pdata[i]);
      end
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 3'($urandom_range(0, S - 1));
      readnum1  = ($urandom_range(0, 3) == 0) ? m_wa : 3'($urandom_range(0, S - 1));
      readnum2  = 3'($urandom_range(0, S - 1));

      g = -1;
      for (int k = 1; k <= int'(N); k++) begin
        int idx;
        idx = (m_last + k) % int'(N);
        if (g < 0 && pend[idx]) g = idx;
      end
      clr     = (g >= 0) && (paddr[g] == rsv_addr);
      exp_rsv = rsv_valid && (!m_busy[rsv_addr] || clr);
      h1      = m_busy[readnum1] || (m_w && m_wa == readnum1);
      h2      = m_busy[readnum2] || (m_w && m_wa == readnum2);
      #1;
      chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1) << g : 32'd0);
      chk("rnd_rsv_ready", 32'(rsv_ready), 32'(exp_rsv));
      chk("rnd_hazard1", 32'(hazard1), 32'(h1));
      chk("rnd_hazard2", 32'(hazard2), 32'(h2));
      tick();
      m_w = (g >= 0);
      if (g >= 0) begin
        m_wa           = paddr[g];
        m_wd           = pdata[g];
        m_busy[m_wa]   = 1'b0;
        m_last         = g;
        pend[g]        = 1'b0;
      end
      if (exp_rsv) m_busy[rsv_addr] = 1'b1;
      chk("rnd_rf_write", 32'(rf_write), 32'(m_w));
      chk("rnd_writenum", 32'(rf_writenum), 32'(m_wa));
      chk("rnd_data_in", 32'(rf_data_in), 32'(m_wd));
      chk("rnd_busy", 32'(busy), 32'(m_busy));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
